// File: rtl/fetch_pkg.sv
// Shared fetch-stage definitions: PC geometry, reset vector, sequencer
// state and next-PC source encodings.
package fetch_pkg;

  localparam int unsigned PC_W = 12;
  localparam logic [PC_W-1:0] RESET_VECTOR = 12'h000;
  localparam int unsigned RAS_DEPTH = 4;

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HOLD,
    HALT
  } pc_seq_state_t;

  // Which value drives next_pc this cycle.
  typedef enum logic [2:0] {
    SRC_BOOT,
    SRC_REDIRECT,
    SRC_PENDING,
    SRC_RET,
    SRC_HOLD,
    SRC_SEQ
  } pc_src_t;

  // True for sources that present a new fetch address.
  function automatic logic src_fetches(pc_src_t s);
    return (s == SRC_REDIRECT) || (s == SRC_PENDING) ||
           (s == SRC_RET) || (s == SRC_SEQ);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack. A push onto a full stack overwrites the
// oldest entry; push and pop together replace the top without changing
// the depth. Only the pointers are reset; stale entries are never read.
module pc_ras #(
  parameter int unsigned W     = 12,
  parameter int unsigned DEPTH = 4
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] data,
  output logic [W-1:0] top,
  output logic         empty,
  output logic         full
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [IW-1:0] ptr;
  logic [IW-1:0] top_idx;
  logic [CW-1:0] count;

  // ptr always names the next free slot, so the top is one below it.
  assign top_idx = ptr - IW'(1);
  assign top     = mem[top_idx];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clock) begin
    if (!reset) begin
      ptr   <= '0;
      count <= '0;
    end else if (push && !pop) begin
      ptr <= ptr + IW'(1);
      if (!full) count <= count + CW'(1);
    end else if (pop && !push && !empty) begin
      ptr   <= top_idx;
      count <= count - CW'(1);
    end
  end

  // Entry storage; nothing is written while reset is asserted.
  always_ff @(posedge clock) begin
    if (reset) begin
      if (push && pop) mem[top_idx] <= data;
      else if (push)   mem[ptr]     <= data;
    end
  end

endmodule

// File: rtl/pc_next_seq.sv
// Next-PC sequencer feeding the PC latch d input. Chooses between reset
// vector, PC+1, taken redirect, parked redirect, predicted return and hold.
// Optional return-address stack is built only when PC_RAS_EN is defined.
//
// Handshake: fetch_valid=1 means next_pc is a new fetch address this cycle;
// fetch_valid=0 means next_pc simply re-presents pc_in (or the reset vector).
// stall is the downstream "not ready": while it is high in HOLD nothing new
// is fetched and redirects are parked in a single-entry pending register.
module pc_next_seq #(
  parameter int unsigned      PC_W         = fetch_pkg::PC_W,
  parameter logic [PC_W-1:0]  RESET_VECTOR = fetch_pkg::RESET_VECTOR,
  parameter int unsigned      RAS_DEPTH    = fetch_pkg::RAS_DEPTH
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [PC_W-1:0] pc_in,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [PC_W-1:0] redirect_target,
  input  logic            call_push,
  input  logic            ret_pop,
  input  logic            halt_req,
  input  logic            resume,
  output logic [PC_W-1:0] next_pc,
  output logic            fetch_valid,
  output logic            pc_halted,
  output logic            redirect_pending,
  output logic            ras_empty,
  output logic            ras_full
);

  fetch_pkg::pc_seq_state_t state_q, state_d;
  fetch_pkg::pc_src_t       src, run_src;

  logic            pend_valid_q;
  logic [PC_W-1:0] pend_target_q;
  logic [PC_W-1:0] pc_plus1;
  logic [PC_W-1:0] ras_top;

  assign pc_plus1 = pc_in + PC_W'(1);

`ifdef PC_RAS_EN
  logic ras_push;
  logic ras_pop;

  // Redirect cycles leave the stack untouched; a pop happens only when the
  // prediction is actually used.
  assign ras_push = call_push && fetch_valid && !redirect_valid;
  assign ras_pop  = (src == fetch_pkg::SRC_RET);

  pc_ras #(
    .W     (PC_W),
    .DEPTH (RAS_DEPTH)
  ) u_ras (
    .clock (clock),
    .reset (reset),
    .push  (ras_push),
    .pop   (ras_pop),
    .data  (pc_plus1),
    .top   (ras_top),
    .empty (ras_empty),
    .full  (ras_full)
  );
`else
  logic unused_ras;

  assign ras_top    = '0;
  assign ras_empty  = 1'b1;
  assign ras_full   = 1'b0;
  assign unused_ras = ^{call_push, ret_pop, 32'(RAS_DEPTH)};
`endif

  // State register; reset forces BOOT regardless of anything else.
  always_ff @(posedge clock) begin
    if (!reset) state_q <= fetch_pkg::BOOT;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      fetch_pkg::BOOT: state_d = fetch_pkg::RUN;
      fetch_pkg::RUN,
      fetch_pkg::HOLD: begin
        if (halt_req)                       state_d = fetch_pkg::HALT;
        else if (src == fetch_pkg::SRC_HOLD) state_d = fetch_pkg::HOLD;
        else                                state_d = fetch_pkg::RUN;
      end
      fetch_pkg::HALT: begin
        if (resume && !halt_req) state_d = fetch_pkg::RUN;
      end
      default: state_d = fetch_pkg::BOOT;
    endcase
  end

  // Output logic: source selection and the next-PC mux.
  always_comb begin
    if (redirect_valid)             run_src = fetch_pkg::SRC_REDIRECT;
    else if (pend_valid_q)          run_src = fetch_pkg::SRC_PENDING;
    else if (ret_pop && !ras_empty) run_src = fetch_pkg::SRC_RET;
    else if (stall)                 run_src = fetch_pkg::SRC_HOLD;
    else                            run_src = fetch_pkg::SRC_SEQ;

    case (state_q)
      fetch_pkg::BOOT: src = fetch_pkg::SRC_BOOT;
      fetch_pkg::RUN:  src = run_src;
      fetch_pkg::HOLD: src = stall ? fetch_pkg::SRC_HOLD : run_src;
      fetch_pkg::HALT: src = fetch_pkg::SRC_HOLD;
      default:         src = fetch_pkg::SRC_BOOT;
    endcase

    case (src)
      fetch_pkg::SRC_BOOT:     next_pc = RESET_VECTOR;
      fetch_pkg::SRC_REDIRECT: next_pc = redirect_target;
      fetch_pkg::SRC_PENDING:  next_pc = pend_target_q;
      fetch_pkg::SRC_RET:      next_pc = ras_top;
      fetch_pkg::SRC_HOLD:     next_pc = pc_in;
      default:                 next_pc = pc_plus1;
    endcase

    fetch_valid      = fetch_pkg::src_fetches(src);
    pc_halted        = (state_q == fetch_pkg::HALT);
    redirect_pending = pend_valid_q;
  end

  // Pending redirect: parked while frozen, cleared once it (or a newer
  // live redirect) drives next_pc.
  always_ff @(posedge clock) begin
    if (!reset) begin
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
    end else if (src == fetch_pkg::SRC_REDIRECT || src == fetch_pkg::SRC_PENDING) begin
      pend_valid_q <= 1'b0;
    end else if (redirect_valid && src == fetch_pkg::SRC_HOLD) begin
      pend_valid_q  <= 1'b1;
      pend_target_q <= redirect_target;
    end
  end

endmodule

// File: tb/tb_pc_next_seq.sv
// Self-checking bench for pc_next_seq: directed scenarios with literal
// expectations, then randomized traffic against a behavioural model.
// Builds with or without PC_RAS_EN.
module tb_pc_next_seq;

  localparam int unsigned PC_W      = 12;
  localparam int unsigned RAS_DEPTH = 4;
  localparam logic [PC_W-1:0] RV    = 12'h000;
`ifdef PC_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset;
  always #5 clock = ~clock;

  logic [PC_W-1:0] pc_in, redirect_target, next_pc;
  logic stall, redirect_valid, call_push, ret_pop, halt_req, resume;
  logic fetch_valid, pc_halted, redirect_pending, ras_empty, ras_full;

  pc_next_seq #(.PC_W(PC_W), .RESET_VECTOR(RV), .RAS_DEPTH(RAS_DEPTH)) dut (
    .clock            (clock),
    .reset            (reset),
    .pc_in            (pc_in),
    .stall            (stall),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .call_push        (call_push),
    .ret_pop          (ret_pop),
    .halt_req         (halt_req),
    .resume           (resume),
    .next_pc          (next_pc),
    .fetch_valid      (fetch_valid),
    .pc_halted        (pc_halted),
    .redirect_pending (redirect_pending),
    .ras_empty        (ras_empty),
    .ras_full         (ras_full)
  );

  // ---------------- scoreboard counters ----------------
  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // mode: 0 boot, 1 run, 2 hold, 3 halt
  // kind: 0 reset vector, 1 redirect, 2 pending, 3 return, 4 hold, 5 sequential
  int              m_mode;
  bit              m_known = 1'b0;
  bit              m_pv;
  logic [PC_W-1:0] m_pt;
  logic [PC_W-1:0] ras_q[$];
  int              e_kind;
  logic [PC_W-1:0] e_pc;
  bit              e_fv;

  function automatic void model_eval();
    bit live;
    live = (m_mode == 1) || (m_mode == 2 && !stall);
    e_fv = 1'b1;
    if (m_mode == 0) begin
      e_kind = 0; e_pc = RV; e_fv = 1'b0;
    end else if (!live) begin
      e_kind = 4; e_pc = pc_in; e_fv = 1'b0;
    end else if (redirect_valid) begin
      e_kind = 1; e_pc = redirect_target;
    end else if (m_pv) begin
      e_kind = 2; e_pc = m_pt;
    end else if (RAS_ON && ret_pop && ras_q.size() > 0) begin
      e_kind = 3; e_pc = ras_q[$];
    end else if (stall) begin
      e_kind = 4; e_pc = pc_in; e_fv = 1'b0;
    end else begin
      e_kind = 5; e_pc = pc_in + 12'd1;
    end
  endfunction

  function automatic void model_update();
    bit push;
    if (!reset) begin
      m_known = 1'b1; m_mode = 0; m_pv = 1'b0; ras_q.delete();
      return;
    end
    if (!m_known) return;
    push = RAS_ON && call_push && e_fv && !redirect_valid;
    if (e_kind == 3) begin
      if (push) ras_q[ras_q.size() - 1] = pc_in + 12'd1;
      else void'(ras_q.pop_back());
    end else if (push) begin
      if (ras_q.size() == RAS_DEPTH) void'(ras_q.pop_front());
      ras_q.push_back(pc_in + 12'd1);
    end
    if (e_kind == 1 || e_kind == 2) m_pv = 1'b0;
    else if (redirect_valid && e_kind == 4) begin m_pv = 1'b1; m_pt = redirect_target; end
    case (m_mode)
      0: m_mode = 1;
      1, 2: m_mode = halt_req ? 3 : ((e_kind == 4) ? 2 : 1);
      default: if (resume && !halt_req) m_mode = 1;
    endcase
  endfunction

  // ---------------- compare / advance ----------------
  // Compare on the falling edge, where all inputs are settled.
  task automatic sample();
    @(negedge clock);
    model_eval();
    if (m_known) begin
      chk("next_pc",          next_pc,          e_pc);
      chk("fetch_valid",      fetch_valid,      e_fv);
      chk("pc_halted",        pc_halted,        (m_mode == 3));
      chk("redirect_pending", redirect_pending, m_pv);
      chk("ras_empty",        ras_empty,        (ras_q.size() == 0));
      chk("ras_full",         ras_full,         (ras_q.size() == RAS_DEPTH));
    end
  endtask

  task automatic advance();
    @(posedge clock);
    model_update();
    #1;
  endtask

  task automatic cycle();
    sample();
    advance();
  endtask

  // ---------------- driver tasks ----------------
  task automatic idle(input logic [PC_W-1:0] pc);
    pc_in = pc; stall = 0; redirect_valid = 0; redirect_target = '0;
    call_push = 0; ret_pop = 0; halt_req = 0; resume = 0;
  endtask

  task automatic drive_random();
    reset           = ($urandom_range(0, 63) != 0);
    pc_in           = ($urandom_range(0, 7) == 0) ? 12'hFFF : 12'($urandom_range(0, 4095));
    stall           = ($urandom_range(0, 3) == 0);
    redirect_valid  = ($urandom_range(0, 4) == 0);
    redirect_target = 12'($urandom_range(0, 4095));
    call_push       = ($urandom_range(0, 3) == 0);
    ret_pop         = ($urandom_range(0, 3) == 0);
    halt_req        = ($urandom_range(0, 15) == 0);
    resume          = ($urandom_range(0, 3) == 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [PC_W-1:0] exp_ret [4];
    exp_ret[0] = 12'h015; exp_ret[1] = 12'h014; exp_ret[2] = 12'h013; exp_ret[3] = 12'h012;

    // T1: reset for two cycles, then boot and first sequential fetch
    idle(12'h000); reset = 0;
    cycle(); cycle();
    reset = 1;
    sample();
    chk("t1_boot_pc", next_pc, 12'h000);
    chk("t1_boot_valid", fetch_valid, 1'b0);
    chk("t1_boot_empty", ras_empty, 1'b1);
    chk("t1_boot_full", ras_full, 1'b0);
    chk("t1_boot_pend", redirect_pending, 1'b0);
    advance();
    sample();
    chk("t1_run_pc", next_pc, 12'h001);
    chk("t1_run_valid", fetch_valid, 1'b1);
    advance();

    // T2: wrap from all-ones
    idle(12'hFFF);
    sample();
    chk("t2_wrap_pc", next_pc, 12'h000);
    chk("t2_wrap_valid", fetch_valid, 1'b1);
    advance();

    // T3: stall into HOLD, park a redirect, release
    idle(12'h010); stall = 1;
    cycle();
    redirect_valid = 1; redirect_target = 12'h2A0;
    sample();
    chk("t3_hold_pc", next_pc, 12'h010);
    chk("t3_hold_valid", fetch_valid, 1'b0);
    advance();
    idle(12'h010);
    sample();
    chk("t3_pend_set", redirect_pending, 1'b1);
    chk("t3_rel_pc", next_pc, 12'h2A0);
    chk("t3_rel_valid", fetch_valid, 1'b1);
    advance();
    sample();
    chk("t3_pend_clr", redirect_pending, 1'b0);
    advance();

    // T4: halt, redirect while halted, resume
    idle(12'h020); halt_req = 1;
    cycle();
    idle(12'h020); redirect_valid = 1; redirect_target = 12'h300;
    sample();
    chk("t4_halted", pc_halted, 1'b1);
    chk("t4_halt_pc", next_pc, 12'h020);
    chk("t4_halt_valid", fetch_valid, 1'b0);
    advance();
    idle(12'h020); resume = 1;
    sample();
    chk("t4_pend", redirect_pending, 1'b1);
    advance();
    idle(12'h020);
    sample();
    chk("t4_resume_pc", next_pc, 12'h300);
    chk("t4_resume_valid", fetch_valid, 1'b1);
    chk("t4_unhalted", pc_halted, 1'b0);
    advance();

    // T5: call then return; return on empty stack falls through
    idle(12'h040); call_push = 1;
    cycle();
    idle(12'h100); ret_pop = 1;
    sample();
`ifdef PC_RAS_EN
    chk("t5_ret_pc", next_pc, 12'h041);
`else
    chk("t5_ret_pc", next_pc, 12'h101);
`endif
    advance();
    sample();
    chk("t5_empty_ret_pc", next_pc, 12'h101);
    chk("t5_empty", ras_empty, 1'b1);
    advance();

    // T6: overfill then drain
    for (int i = 0; i < 5; i++) begin
      idle(12'(12'h010 + i)); call_push = 1;
      cycle();
    end
    idle(12'h200);
    sample();
    chk("t6_full", ras_full, RAS_ON);
    advance();
    for (int i = 0; i < 4; i++) begin
      idle(12'h200); ret_pop = 1;
      sample();
      chk("t6_pop_pc", next_pc, RAS_ON ? exp_ret[i] : 12'h201);
      advance();
    end
    idle(12'h200);
    sample();
    chk("t6_drained", ras_empty, 1'b1);
    advance();

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      drive_random();
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
